// File: rtl/mem_rd_streamer.sv
// Sequential RAM reader: issues credit-limited reads, absorbs the RAM read
// latency in a skid FIFO and streams the words out with last marking.
module mem_rd_streamer #(
    parameter int DW         = 8,
    parameter int DEPTH      = 8,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   length,
    output logic          busy,
    output logic          done,
    output logic          mem_rden,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int OW = $clog2(SKID_DEPTH + RD_LATENCY + 2) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           issue_left_q, issue_left_d;
    logic [AW:0]           accept_left_q, accept_left_d;
    logic                  rden_q, rden_d;
    logic                  rlast_q, rlast_d;
    logic [AW-1:0]         raddr_q, raddr_d;
    logic                  done_q, done_d;
    logic [RD_LATENCY-1:0] vld_q, lst_q;

    logic [DW:0]           fifo_q [SKID_DEPTH];
    logic [DW:0]           head;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  fifo_wr, fifo_rd;
    logic [OW-1:0]         occ;
    logic                  credit_ok, issue, last_acc;
    logic [AW-1:0]         cur_ptr;
    logic [AW:0]           cur_left;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_wr   = vld_q[RD_LATENCY-1];
    assign head      = fifo_q[rptr_q];
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? head[DW-1:0] : '0;
    assign out_last  = out_valid & head[DW];
    assign fifo_rd   = out_valid & out_ready;
    assign last_acc  = fifo_rd && (accept_left_q == (AW+1)'(1));

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_rden  = rden_q;
    assign mem_raddr = raddr_q;

    // Every issued-but-unpopped read owns a FIFO slot; a pop this cycle frees one.
    always_comb begin
        occ = OW'(cnt_q) + OW'(rden_q) - OW'(fifo_rd);
        for (int i = 0; i < RD_LATENCY; i++) begin
            occ = occ + OW'(vld_q[i]);
        end
    end
    assign credit_ok = (occ < OW'(SKID_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && length != '0) state_d = RUN;
            end
            RUN: begin
                if (issue_left_q == '0 ||
                    (issue && issue_left_q == (AW+1)'(1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (last_acc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue         = 1'b0;
        done_d        = 1'b0;
        cur_ptr       = rd_ptr_q;
        cur_left      = issue_left_q;
        accept_left_d = fifo_rd ? accept_left_q - (AW+1)'(1) : accept_left_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_ptr       = start_addr;
                    cur_left      = length;
                    accept_left_d = length;
                    issue         = (length != '0);
                    done_d        = (length == '0);
                end
            end
            RUN:     issue  = (issue_left_q != '0) && credit_ok;
            DRAIN:   done_d = last_acc;
            default: ;
        endcase
        rd_ptr_d     = issue ? cur_ptr + AW'(1) : cur_ptr;
        issue_left_d = issue ? cur_left - (AW+1)'(1) : cur_left;
        rden_d       = issue;
        rlast_d      = issue && (cur_left == (AW+1)'(1));
        raddr_d      = issue ? cur_ptr : raddr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            issue_left_q  <= '0;
            accept_left_q <= '0;
            rden_q        <= 1'b0;
            rlast_q       <= 1'b0;
            raddr_q       <= '0;
            done_q        <= 1'b0;
            vld_q         <= '0;
            lst_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            issue_left_q  <= issue_left_d;
            accept_left_q <= accept_left_d;
            rden_q        <= rden_d;
            rlast_q       <= rlast_d;
            raddr_q       <= raddr_d;
            done_q        <= done_d;
            vld_q[0]      <= rden_q;
            lst_q[0]      <= rlast_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
            if (fifo_wr) wptr_q <= ptr_inc(wptr_q);
            if (fifo_rd) rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_q[wptr_q] <= {lst_q[RD_LATENCY-1], mem_rdata};
    end

`ifndef SYNTHESIS
    a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (start && !busy) |-> (length <= (AW+1)'(DEPTH)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CW'(SKID_DEPTH));
`endif

endmodule

// File: doc/mem_rd_streamer.md
Name: mem_rd_streamer

Overview:
- Reader-side companion to the team's simple-dual-port RAM wrapper.
- Accepts a (start address, word count) command and issues sequential reads on the RAM read port.
- Absorbs the fixed RAM read latency in a small skid FIFO and presents the words as a valid/ready stream with last-word marking.
- Used by the packet client to replay buffered segments toward the MAC with full backpressure support.

Parameters:
- DW, 8, data width; must match the RAM width.
- DEPTH, 8, RAM depth in words; power of 2, ≥2; AW = $clog2(DEPTH).
- RD_LATENCY, 2, cycles from rden-high to valid rdata; 2 when RAM OUTREG="ON", 1 when "OFF"; range 1..4.
- SKID_DEPTH, 4, skid FIFO entries; must be ≥ RD_LATENCY+2.

Ports:
- clk, in, 1, single clock for all logic.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, command strobe; sampled only when busy=0.
- start_addr, in, AW, first RAM word address.
- length, in, AW+1, number of words to read; 0 is legal.
- busy, out, 1, command in progress.
- done, out, 1, one-cycle pulse when the command completes.
- mem_rden, out, 1, RAM read enable (registered).
- mem_raddr, out, AW, RAM read address (registered).
- mem_rdata, in, DW, RAM read data.
- out_data, out, DW, stream data.
- out_valid, out, 1, stream valid.
- out_last, out, 1, marks the final word of the command.
- out_ready, in, 1, downstream ready.

Behaviour:
- Reset (async assert, sync-released by top level):
  - FSM=IDLE; busy, done, mem_rden, out_valid, out_last = 0.
  - mem_raddr = 0; FIFO empty; in-flight pipe cleared.
  - Reset mid-command abandons the command; no done pulse is issued.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: on start=1, latch rd_ptr=start_addr, issue_left=length, accept_left=length. Next state is RUN if length≠0. If length=0, go to IDLE with done=1 next cycle and no reads issued. busy=1 from the cycle after start until done.
  - RUN: issue one read per cycle while issue_left>0 and (in_flight + fifo_count) < SKID_DEPTH. A credit check in the same cycle guarantees the FIFO never overflows. Each issue increments rd_ptr modulo DEPTH (wraps DEPTH-1→0) and decrements issue_left. When issue_left reaches 0, go to DRAIN.
  - DRAIN: no reads issued. When the word with out_last=1 is accepted (out_valid & out_ready), go to IDLE. done pulses in the following cycle; busy drops in that same cycle.
- start while busy=1 is ignored (no queueing).
- Read pipeline:
  - An RD_LATENCY-deep valid/last shift register tracks in-flight reads.
  - mem_rdata is written to the FIFO in the cycle the tracked valid emerges, i.e. RD_LATENCY cycles after mem_rden was high.
  - RAM-side rdata_vld is not used.
- Output:
  - FIFO head is registered; out_valid/out_data/out_last are stable while out_valid=1 and out_ready=0 (AXI-S rules).
  - Transfer occurs on out_valid & out_ready.
  - Simultaneous FIFO write and read in one cycle is supported; count is unchanged.
- Latency: start at edge 0 → mem_rden=1 in cycle 1 → first out_valid in cycle 2+RD_LATENCY (cycle 4 at default).
- Throughput: 1 word/cycle sustained with out_ready held at 1.
- Counter widths: issue_left, accept_left are AW+1 bits. length > DEPTH is illegal (assertion in simulation).

Test Plan:
- Basic read: DEPTH=8, RAM[i]=0xA0+i; start_addr=2, length=4, out_ready=1. Expected: mem_rden cycles 1–4 with addr 2,3,4,5; out_data A2,A3,A4,A5 in cycles 4–7; out_last in cycle 7; done in cycle 8.
- Wrap: start_addr=6, length=4. Expected: addresses 6,7,0,1; data A6,A7,A0,A1.
- Backpressure: length=8, out_ready low for cycles 5–12. Expected: FIFO never exceeds 4 entries; mem_rden deasserts when credits are exhausted; stream resumes with no loss or duplication; all 8 words arrive in order.
- Zero length: start with length=0. Expected: done=1 in cycle 1; mem_rden and out_valid never assert.
- Start while busy: second start (addr 0, len 2) during a length=4 run. Expected: ignored; only 4 words output; one done pulse.
- Reset mid-run: rst_n low in cycle 5 of a length=8 run. Expected: all outputs 0 immediately; a new command after release streams correctly from its own start_addr.
